// File: rtl/alarm_ctrl.sv
// alarm_ctrl
//   Alarm-clock alarm sequencer. Holds the alarm time (stepped by debounced
//   button pulses while in set mode), compares it against the running
//   time-of-day on each minute tick, and runs the ring/snooze state machine
//   that drives the buzzer/LED and the set-mode BCD display digits.
//
//   State table (state_o encoding)
//     state  | meaning
//     IDLE 0 | armed or disarmed, waiting for a match or set mode
//     SET  1 | alarm time may be stepped; matches are ignored
//     RING 2 | buzzer on; auto-off after RING_MIN minute ticks
//     SNOOZE3| buzzer paused; rings again after SNOOZE_MIN minute ticks
//
//   Ports
//     clk_i, rst_i            clock, asynchronous active-high reset
//     set_en_i, alarm_en_i    level switches: set mode, alarm armed
//     hour_inc_i, min_inc_i   one-clock pulses stepping the alarm time
//     stop_i, snooze_i        one-clock pulses from the ring controls
//     min_tick_i              one-clock pulse, cur_* already hold new minute
//     cur_hour_i, cur_min_i   time of day (0..23, 0..59)
//     alarm_hour_o/alarm_min_o registered alarm time
//     ahour1_o..amin2_o       BCD tens/units of the alarm time
//     ringing_o               registered, high iff in RING
//     state_o                 current state encoding

module alarm_ctrl #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_en_i,
  input  logic       alarm_en_i,
  input  logic       hour_inc_i,
  input  logic       min_inc_i,
  input  logic       stop_i,
  input  logic       snooze_i,
  input  logic       min_tick_i,
  input  logic [5:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  output logic [5:0] alarm_hour_o,
  output logic [5:0] alarm_min_o,
  output logic [3:0] ahour1_o,
  output logic [3:0] ahour2_o,
  output logic [3:0] amin1_o,
  output logic [3:0] amin2_o,
  output logic       ringing_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET    = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam logic [5:0] RING_LIM   = 6'(RING_MIN);
  localparam logic [5:0] SNOOZE_LIM = 6'(SNOOZE_MIN);

  state_t     state_q, state_d;
  logic [5:0] alarm_hour_q, alarm_hour_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [5:0] snz_cnt_q, snz_cnt_d;
  logic       ringing_q, ringing_d;

  logic       match;
  logic [5:0] ring_cnt_inc;
  logic [5:0] snz_cnt_inc;

  // Binary (0..63) to BCD. The units digit is taken modulo 16: the true
  // result is 0..9, so subtracting the low nibble of tens*10 from the low
  // nibble of the value is exact and avoids a full-width subtractor.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] base;
    if (v >= 6'd60)      tens = 4'd6;
    else if (v >= 6'd50) tens = 4'd5;
    else if (v >= 6'd40) tens = 4'd4;
    else if (v >= 6'd30) tens = 4'd3;
    else if (v >= 6'd20) tens = 4'd2;
    else if (v >= 6'd10) tens = 4'd1;
    else                 tens = 4'd0;
    case (tens)
      4'd1:    base = 4'd10;
      4'd2:    base = 4'd4;
      4'd3:    base = 4'd14;
      4'd4:    base = 4'd8;
      4'd5:    base = 4'd2;
      4'd6:    base = 4'd12;
      default: base = 4'd0;
    endcase
    return {tens, v[3:0] - base};
  endfunction

  assign match = min_tick_i & alarm_en_i &
                 (cur_hour_i == alarm_hour_q) & (cur_min_i == alarm_min_q);

  assign ring_cnt_inc = ring_cnt_q + 6'd1;
  assign snz_cnt_inc  = snz_cnt_q + 6'd1;

  // Alarm time stepping: hour pulse takes precedence, minute never carries.
  always_comb begin
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    if (state_q == SET) begin
      if (hour_inc_i) begin
        alarm_hour_d = (alarm_hour_q == 6'd23) ? 6'd0 : alarm_hour_q + 6'd1;
      end else if (min_inc_i) begin
        alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      IDLE: begin
        if (set_en_i) begin
          state_d = SET;
        end else if (match) begin
          state_d    = RING;
          ring_cnt_d = 6'd0;
        end
      end
      SET: begin
        if (!set_en_i) state_d = IDLE;
      end
      RING: begin
        if (set_en_i) begin
          state_d = SET;
        end else if (stop_i || !alarm_en_i) begin
          state_d = IDLE;
        end else if (snooze_i) begin
          state_d   = SNOOZE;
          snz_cnt_d = 6'd0;
        end else if (min_tick_i) begin
          ring_cnt_d = ring_cnt_inc;
          if (ring_cnt_inc == RING_LIM) state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (set_en_i) begin
          state_d = SET;
        end else if (stop_i || !alarm_en_i) begin
          state_d = IDLE;
        end else if (min_tick_i) begin
          snz_cnt_d = snz_cnt_inc;
          if (snz_cnt_inc == SNOOZE_LIM) begin
            state_d    = RING;
            ring_cnt_d = 6'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered so the buzzer line is glitch-free and tracks the state exactly.
  assign ringing_d = (state_d == RING);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      alarm_hour_q <= 6'd0;
      alarm_min_q  <= 6'd0;
      ring_cnt_q   <= 6'd0;
      snz_cnt_q    <= 6'd0;
      ringing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      ringing_q    <= ringing_d;
    end
  end

  assign alarm_hour_o       = alarm_hour_q;
  assign alarm_min_o        = alarm_min_q;
  assign {ahour1_o, ahour2_o} = to_bcd(alarm_hour_q);
  assign {amin1_o, amin2_o}   = to_bcd(alarm_min_q);
  assign ringing_o          = ringing_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  localparam int SNOOZE_MIN = 5;
  localparam int RING_MIN   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_en = 1'b0, alarm_en = 1'b0;
  logic       hour_inc = 1'b0, min_inc = 1'b0, stop = 1'b0, snooze = 1'b0, min_tick = 1'b0;
  logic [5:0] cur_hour = 6'd0, cur_min = 6'd0;
  logic [5:0] alarm_hour, alarm_min;
  logic [3:0] ahour1, ahour2, amin1, amin2;
  logic       ringing;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: mode name numbers are the externally visible encoding;
  // timers are kept as "ticks remaining".
  localparam int M_IDLE = 0, M_SET = 1, M_RING = 2, M_SNOOZE = 3;
  int m_state = M_IDLE, m_hour = 0, m_min = 0, m_ring_left = 0, m_snz_left = 0;

  alarm_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN)) dut (
    .clk_i(clk), .rst_i(rst), .set_en_i(set_en), .alarm_en_i(alarm_en),
    .hour_inc_i(hour_inc), .min_inc_i(min_inc), .stop_i(stop), .snooze_i(snooze),
    .min_tick_i(min_tick), .cur_hour_i(cur_hour), .cur_min_i(cur_min),
    .alarm_hour_o(alarm_hour), .alarm_min_o(alarm_min),
    .ahour1_o(ahour1), .ahour2_o(ahour2), .amin1_o(amin1), .amin2_o(amin2),
    .ringing_o(ringing), .state_o(state)
  );

  always #5 clk = ~clk;

  // One clock: model evaluates the same inputs the DUT samples, then pulses clear.
  task automatic step();
    int ns, nh, nm, nrl, nsl;
    bit hit;
    ns = m_state; nh = m_hour; nm = m_min; nrl = m_ring_left; nsl = m_snz_left;
    hit = min_tick && alarm_en && (int'(cur_hour) == m_hour) && (int'(cur_min) == m_min);
    if (m_state == M_SET) begin
      if (hour_inc)     nh = (m_hour + 1) % 24;
      else if (min_inc) nm = (m_min + 1) % 60;
    end
    case (m_state)
      M_IDLE: if (set_en) ns = M_SET; else if (hit) begin ns = M_RING; nrl = RING_MIN; end
      M_SET:  if (!set_en) ns = M_IDLE;
      M_RING: begin
        if (set_en) ns = M_SET;
        else if (stop || !alarm_en) ns = M_IDLE;
        else if (snooze) begin ns = M_SNOOZE; nsl = SNOOZE_MIN; end
        else if (min_tick) begin nrl = m_ring_left - 1; if (nrl == 0) ns = M_IDLE; end
      end
      default: begin
        if (set_en) ns = M_SET;
        else if (stop || !alarm_en) ns = M_IDLE;
        else if (min_tick) begin
          nsl = m_snz_left - 1;
          if (nsl == 0) begin ns = M_RING; nrl = RING_MIN; end
        end
      end
    endcase
    @(posedge clk); #1;
    m_state = ns; m_hour = nh; m_min = nm; m_ring_left = nrl; m_snz_left = nsl;
    hour_inc = 0; min_inc = 0; stop = 0; snooze = 0; min_tick = 0;
  endtask

  task automatic test_reset_init();
    @(posedge clk); #1; @(posedge clk); #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL init_state got=%0d want=0", state); end
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL init_ringing got=%0d want=0", ringing); end
    total++; if ({alarm_hour, alarm_min} !== 12'd0) begin bad++; $display("FAIL init_alarm got=%0d:%0d want=0:0", alarm_hour, alarm_min); end
    rst = 0;
    step();
  endtask

  task automatic test_setting();
    set_en = 1; step();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL set_enter got=%0d want=1", state); end
    for (int i = 0; i < 24; i++) begin hour_inc = 1; step(); end
    total++; if (alarm_hour !== 6'd0) begin bad++; $display("FAIL hour_wrap got=%0d want=0", alarm_hour); end
    for (int i = 0; i < 61; i++) begin min_inc = 1; step(); end
    total++; if (alarm_min !== 6'd1 || amin1 !== 4'd0 || amin2 !== 4'd1) begin
      bad++; $display("FAIL min_wrap got=%0d (%0d,%0d) want=1 (0,1)", alarm_min, amin1, amin2); end
    hour_inc = 1; min_inc = 1; step();
    total++; if (alarm_hour !== 6'd1 || alarm_min !== 6'd1) begin
      bad++; $display("FAIL both_inc got=%0d:%0d want=1:1", alarm_hour, alarm_min); end
    total++; if (ahour1 !== 4'd0 || ahour2 !== 4'd1) begin
      bad++; $display("FAIL hour_bcd got=%0d%0d want=01", ahour1, ahour2); end
    set_en = 0; step();
  endtask

  // Uses the model only to count how many pulses reach the target time.
  task automatic set_alarm(input int h, input int m);
    set_en = 1; step();
    while (m_hour != h) begin hour_inc = 1; step(); end
    while (m_min != m)  begin min_inc = 1; step(); end
    set_en = 0; step();
  endtask

  task automatic ring_now();
    cur_hour = 6'd7; cur_min = 6'd30; min_tick = 1; step();
    cur_min = 6'd31;
  endtask

  task automatic test_ring_stop();
    set_alarm(7, 30);
    total++; if (alarm_hour !== 6'd7 || alarm_min !== 6'd30 || amin1 !== 4'd3 || amin2 !== 4'd0) begin
      bad++; $display("FAIL alarm_0730 got=%0d:%0d want=7:30", alarm_hour, alarm_min); end
    alarm_en = 1;
    ring_now();
    total++; if (ringing !== 1'b1 || state !== 2'd2) begin
      bad++; $display("FAIL match_ring got=%0d/%0d want=1/2", ringing, state); end
    stop = 1; step();
    total++; if (ringing !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL stop got=%0d/%0d want=0/0", ringing, state); end
    set_en = 1; step();
    ring_now();
    total++; if (ringing !== 1'b0 || state !== 2'd1) begin
      bad++; $display("FAIL set_suppress got=%0d/%0d want=0/1", ringing, state); end
    set_en = 0; step();
  endtask

  task automatic test_snooze();
    ring_now();
    snooze = 1; step();
    total++; if (ringing !== 1'b0 || state !== 2'd3) begin
      bad++; $display("FAIL snooze_enter got=%0d/%0d want=0/3", ringing, state); end
    for (int i = 0; i < SNOOZE_MIN - 1; i++) begin
      min_tick = 1; step();
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL snooze_tick%0d got=%0d want=0", i, ringing); end
    end
    min_tick = 1; step();
    total++; if (ringing !== 1'b1 || state !== 2'd2) begin
      bad++; $display("FAIL snooze_expire got=%0d/%0d want=1/2", ringing, state); end
    stop = 1; step();
  endtask

  task automatic test_autooff_priority();
    ring_now();
    min_tick = 1; step();
    total++; if (ringing !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL auto_off got=%0d/%0d want=0/0", ringing, state); end
    ring_now();
    stop = 1; snooze = 1; step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL stop_over_snooze got=%0d want=0", state); end
    snooze = 1; step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL stray_snooze got=%0d want=0", state); end
  endtask

  task automatic test_disarm();
    ring_now();
    snooze = 1; step();
    alarm_en = 0; step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL disarm_snooze got=%0d want=0", state); end
    ring_now();
    total++; if (ringing !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL disarm_match got=%0d/%0d want=0/0", ringing, state); end
    alarm_en = 1;
  endtask

  task automatic test_reset_mid_ring();
    set_alarm(1, 2);
    cur_hour = 6'd1; cur_min = 6'd2; min_tick = 1; step();
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL pre_reset_ring got=%0d want=1", ringing); end
    #2 rst = 1;
    #1;
    total++; if (ringing !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL async_reset got=%0d/%0d want=0/0", ringing, state); end
    total++; if (alarm_hour !== 6'd0 || alarm_min !== 6'd0) begin
      bad++; $display("FAIL async_reset_alarm got=%0d:%0d want=0:0", alarm_hour, alarm_min); end
    #1 rst = 0;
    m_state = M_IDLE; m_hour = 0; m_min = 0; m_ring_left = 0; m_snz_left = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] eh1, eh2, em1, em2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) set_en = ~set_en;
      if ($urandom_range(0, 39) == 0) alarm_en = ~alarm_en;
      hour_inc = ($urandom_range(0, 3) == 0);
      min_inc  = ($urandom_range(0, 2) == 0);
      stop     = ($urandom_range(0, 19) == 0);
      snooze   = ($urandom_range(0, 7) == 0);
      min_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        cur_hour = 6'(m_hour); cur_min = 6'(m_min);
      end else begin
        cur_hour = 6'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59));
      end
      step();
      eh1 = 4'(m_hour / 10); eh2 = 4'(m_hour % 10);
      em1 = 4'(m_min / 10);  em2 = 4'(m_min % 10);
      total++;
      if (state !== 2'(m_state) || ringing !== (m_state == M_RING) ||
          alarm_hour !== 6'(m_hour) || alarm_min !== 6'(m_min) ||
          {ahour1, ahour2, amin1, amin2} !== {eh1, eh2, em1, em2}) begin
        bad++;
        $display("FAIL random cyc=%0d got st=%0d r=%0d %0d:%0d bcd=%0d%0d:%0d%0d want st=%0d %0d:%0d",
                 n, state, ringing, alarm_hour, alarm_min, ahour1, ahour2, amin1, amin2,
                 m_state, m_hour, m_min);
      end
    end
  endtask

  initial begin
    test_reset_init();
    test_setting();
    test_ring_stop();
    test_snooze();
    test_autooff_priority();
    test_disarm();
    test_reset_mid_ring();
    alarm_en = 1;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
